uc_axi_master: RTL and testbench

- Single-beat AXI4 master. Converts a simple command stream (write/read, address, byte) into AXI4 transactions and returns one response per command.
- Drives the slave port of the UART register map, either from a host-side controller or directly from a testbench.
- Forms the initiator end of the same AXI4 link: 8-bit data, INCR burst, len = 0.
- Only one transaction is in flight at a time.

---
 rtl/uc_axi_master_pkg.sv | 26 ++
 rtl/uc_axi_master.sv | 211 +++++++++++++++++++++
 tb/tb_uc_axi_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uc_axi_master_pkg.sv
// Shared AXI4 encodings and FSM state type for the single-beat command-to-AXI master.
package uc_axi_master_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StRsp
  } mst_state_e;

endpackage

// File: rtl/uc_axi_master.sv
// Single-beat AXI4 master: turns one command into one AXI transaction and returns one response.
module uc_axi_master
  import uc_axi_master_pkg::*;
#(
  parameter int unsigned ATX_DATA_W = 8,
  parameter int unsigned ATX_ADDR_W = 32,
  parameter int unsigned ATX_ID_W   = 5,
  parameter int unsigned ATX_LEN_W  = 8,
  parameter int unsigned ATX_RESP_W = 2,
  parameter logic [ATX_ID_W-1:0] MST_ID = ATX_ID_W'(1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_wr_i,
  input  logic [ATX_ADDR_W-1:0] cmd_addr_i,
  input  logic [ATX_DATA_W-1:0] cmd_wdata_i,
  input  logic                  cmd_vld_i,
  output logic                  cmd_rdy_o,
  output logic                  rsp_wr_o,
  output logic [ATX_DATA_W-1:0] rsp_rdata_o,
  output logic [ATX_RESP_W-1:0] rsp_resp_o,
  output logic                  rsp_err_o,
  output logic                  rsp_vld_o,
  input  logic                  rsp_rdy_i,
  output logic [ATX_ID_W-1:0]   m_awid_o,
  output logic [ATX_ADDR_W-1:0] m_awaddr_o,
  output logic [1:0]            m_awburst_o,
  output logic [ATX_LEN_W-1:0]  m_awlen_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [ATX_DATA_W-1:0] m_wdata_o,
  output logic                  m_wlast_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  input  logic [ATX_ID_W-1:0]   m_bid_i,
  input  logic [ATX_RESP_W-1:0] m_bresp_i,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o,
  output logic [ATX_ID_W-1:0]   m_arid_o,
  output logic [ATX_ADDR_W-1:0] m_araddr_o,
  output logic [1:0]            m_arburst_o,
  output logic [ATX_LEN_W-1:0]  m_arlen_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [ATX_ID_W-1:0]   m_rid_i,
  input  logic [ATX_DATA_W-1:0] m_rdata_i,
  input  logic [ATX_RESP_W-1:0] m_rresp_i,
  input  logic                  m_rlast_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o
);

  mst_state_e            state_q, state_d;
  logic [ATX_ADDR_W-1:0] addr_q, addr_d;
  logic [ATX_DATA_W-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ATX_DATA_W-1:0] rdata_q, rdata_d;
  logic [ATX_RESP_W-1:0] resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  aw_hs, w_hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    err_d     = err_q;
    aw_hs     = awvalid_q & m_awready_i;
    w_hs      = wvalid_q & m_wready_i;

    unique case (state_q)
      StIdle: begin
        if (cmd_vld_i) begin
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          wr_d    = cmd_wr_i;
          if (cmd_wr_i) begin
            state_d   = StWrReq;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = StRdReq;
            arvalid_d = 1'b1;
          end
        end
      end
      StWrReq: begin
        // AW and W complete independently; sticky flags cover either order or both at once.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d   = StWrResp;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StWrResp: begin
        if (m_bvalid_i & bready_q) begin
          resp_d   = m_bresp_i;
          err_d    = (m_bid_i != MST_ID);
          rdata_d  = '0;
          bready_d = 1'b0;
          state_d  = StRsp;
        end
      end
      StRdReq: begin
        if (arvalid_q & m_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdResp;
        end
      end
      StRdResp: begin
        if (m_rvalid_i & rready_q) begin
          rdata_d  = m_rdata_i;
          resp_d   = m_rresp_i;
          err_d    = (m_rid_i != MST_ID) | ~m_rlast_i;
          rready_d = 1'b0;
          state_d  = StRsp;
        end
      end
      StRsp: begin
        if (rsp_rdy_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cmd_rdy_o   = (state_q == StIdle);
  assign rsp_vld_o   = (state_q == StRsp);
  assign rsp_wr_o    = wr_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_resp_o  = resp_q;
  assign rsp_err_o   = err_q;

  assign m_awid_o    = MST_ID;
  assign m_awaddr_o  = addr_q;
  assign m_awburst_o = BurstIncr;
  assign m_awlen_o   = '0;
  assign m_awvalid_o = awvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wlast_o   = 1'b1;
  assign m_wvalid_o  = wvalid_q;
  assign m_bready_o  = bready_q;
  assign m_arid_o    = MST_ID;
  assign m_araddr_o  = addr_q;
  assign m_arburst_o = BurstIncr;
  assign m_arlen_o   = '0;
  assign m_arvalid_o = arvalid_q;
  assign m_rready_o  = rready_q;

endmodule

// File: tb/tb_uc_axi_master.sv
// Scoreboard bench for uc_axi_master with a reactive single-beat AXI slave model.
module tb_uc_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_wr_i, cmd_vld_i, cmd_rdy_o;
  logic [31:0] cmd_addr_i;
  logic [7:0]  cmd_wdata_i;
  logic        rsp_wr_o, rsp_err_o, rsp_vld_o, rsp_rdy_i;
  logic [7:0]  rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic [4:0]  m_awid_o, m_arid_o, m_bid_i, m_rid_i;
  logic [31:0] m_awaddr_o, m_araddr_o;
  logic [1:0]  m_awburst_o, m_arburst_o, m_bresp_i, m_rresp_i;
  logic [7:0]  m_awlen_o, m_arlen_o, m_wdata_o, m_rdata_i;
  logic        m_awvalid_o, m_awready_i, m_wlast_o, m_wvalid_o, m_wready_i;
  logic        m_bvalid_i, m_bready_o, m_arvalid_o, m_arready_i;
  logic        m_rlast_i, m_rvalid_i, m_rready_o;

  always #5 clk = ~clk;

  uc_axi_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_wr_i(cmd_wr_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o),
    .rsp_wr_o(rsp_wr_o), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .rsp_err_o(rsp_err_o), .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awburst_o(m_awburst_o),
    .m_awlen_o(m_awlen_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o),
    .m_wready_i(m_wready_i),
    .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arburst_o(m_arburst_o),
    .m_arlen_o(m_arlen_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );

  typedef struct packed {
    logic       wr;
    logic [7:0] rdata;
    logic [1:0] resp;
    logic       err;
  } rsp_t;

  rsp_t sb[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;
  int   hs_cyc;

  // Slave knobs (written by the test sequence) and observations (written by the slave).
  int          aw_delay, w_delay;
  logic [4:0]  s_bid, s_rid;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_rlast;
  bit          b_hold;
  int          aw_cyc = 0, w_cyc = 0, b_hs = 0, r_hs = 0;
  logic [31:0] aw_seen, ar_seen;
  logic [7:0]  w_seen;
  logic [7:0]  mem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  // Readies/valids are decided at negedge from the DUT's registered outputs; a handshake
  // decided here completes at the following posedge.
  initial begin : slave
    bit aw_fire, w_fire, ar_fire, b_fire, r_fire, aw_got, w_got, ar_got;
    int aw_cnt, w_cnt;
    {aw_fire, w_fire, ar_fire, b_fire, r_fire, aw_got, w_got, ar_got} = '0;
    aw_cnt = 0; w_cnt = 0;
    {m_awready_i, m_wready_i, m_arready_i, m_bvalid_i, m_rvalid_i} = '0;
    m_bid_i = '0; m_bresp_i = '0; m_rid_i = '0; m_rresp_i = '0; m_rlast_i = 1'b0;
    m_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {aw_fire, w_fire, ar_fire, b_fire, r_fire, aw_got, w_got, ar_got} = '0;
        aw_cnt = 0; w_cnt = 0;
        {m_awready_i, m_wready_i, m_arready_i, m_bvalid_i, m_rvalid_i} = '0;
        continue;
      end
      if (aw_fire) begin aw_got = 1; aw_fire = 0; end
      if (w_fire)  begin w_got = 1;  w_fire = 0;  end
      if (ar_fire) begin ar_got = 1; ar_fire = 0; end
      if (b_fire)  begin m_bvalid_i = 1'b0; b_fire = 0; end
      if (r_fire)  begin m_rvalid_i = 1'b0; r_fire = 0; end
      if (m_awvalid_o) aw_cyc++;
      if (m_wvalid_o)  w_cyc++;
      m_awready_i = m_awvalid_o && (aw_cnt >= aw_delay);
      if (m_awready_i) begin aw_fire = 1; aw_cnt = 0; aw_seen = m_awaddr_o; end
      else if (m_awvalid_o) aw_cnt++;
      m_wready_i = m_wvalid_o && (w_cnt >= w_delay);
      if (m_wready_i) begin w_fire = 1; w_cnt = 0; w_seen = m_wdata_o; end
      else if (m_wvalid_o) w_cnt++;
      m_arready_i = m_arvalid_o;
      if (m_arready_i) begin ar_fire = 1; ar_seen = m_araddr_o; end
      if (aw_got && w_got && !m_bvalid_i && !b_hold) begin
        mem[aw_seen] = w_seen;
        m_bvalid_i = 1'b1; m_bid_i = s_bid; m_bresp_i = s_bresp;
        aw_got = 0; w_got = 0;
      end
      if (ar_got && !m_rvalid_i) begin
        m_rvalid_i = 1'b1; m_rid_i = s_rid; m_rresp_i = s_rresp; m_rlast_i = s_rlast;
        m_rdata_i = mem.exists(ar_seen) ? mem[ar_seen] : 8'h00;
        ar_got = 0;
      end
      if (m_bvalid_i && m_bready_o) begin b_fire = 1; b_hs++; end
      if (m_rvalid_i && m_rready_o) begin r_fire = 1; r_hs++; end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] data);
    int n = 0;
    @(negedge clk);
    cmd_wr_i = wr; cmd_addr_i = addr; cmd_wdata_i = data; cmd_vld_i = 1'b1;
    while (!cmd_rdy_o && n < 50) begin @(negedge clk); n++; end
    if (!cmd_rdy_o) begin
      n_chk++;
      $display("FAIL cmd_accept: cmd_rdy_o=%0b after %0d cycles, required 1", cmd_rdy_o, n);
    end
    @(posedge clk); #1;
    hs_cyc = cyc;
    cmd_vld_i = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_vld_o && lat < 100);
    if (!rsp_vld_o) begin
      n_chk++;
      $display("FAIL rsp_timeout: rsp_vld_o=0 after %0d cycles, required 1", lat);
    end
  endtask

  // Scoreboard consumer: pops the oldest expectation and compares it with the presented response.
  task automatic ack_rsp(input string name);
    rsp_t exp, got;
    got = {rsp_wr_o, rsp_rdata_o, rsp_resp_o, rsp_err_o};
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL %s: response wr=%0b rdata=%02h with empty scoreboard", name, got.wr, got.rdata);
    end else begin
      exp = sb.pop_front();
      if (!rsp_vld_o || got !== exp)
        $display("FAIL %s: got vld=%0b wr=%0b rdata=%02h resp=%02b err=%0b, required vld=1 wr=%0b rdata=%02h resp=%02b err=%0b",
                 name, rsp_vld_o, got.wr, got.rdata, got.resp, got.err,
                 exp.wr, exp.rdata, exp.resp, exp.err);
      else n_pass++;
    end
    rsp_rdy_i = 1'b1;
    @(posedge clk); #1;
    rsp_rdy_i = 1'b0;
  endtask

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [7:0] data,
                         input string name);
    int lat;
    issue_cmd(wr, addr, data);
    wait_rsp(lat);
    ack_rsp(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_vld_i = 1'b0; rsp_rdy_i = 1'b0;
    cmd_wr_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({cmd_rdy_o, m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o, rsp_vld_o}
        !== 7'b1000000)
      $display("FAIL reset_handshake: got %07b required 1000000", {cmd_rdy_o, m_awvalid_o,
               m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o, rsp_vld_o});
    else n_pass++;
    n_chk++;
    if ({rsp_wr_o, rsp_rdata_o, rsp_resp_o, rsp_err_o, m_awaddr_o, m_wdata_o} !== '0)
      $display("FAIL reset_regs: rsp=%0b/%02h/%02b/%0b awaddr=%08h wdata=%02h required all 0",
               rsp_wr_o, rsp_rdata_o, rsp_resp_o, rsp_err_o, m_awaddr_o, m_wdata_o);
    else n_pass++;
    n_chk++;
    if ({m_awburst_o, m_arburst_o, m_awlen_o, m_arlen_o, m_wlast_o, m_awid_o, m_arid_o}
        !== {2'b01, 2'b01, 8'h00, 8'h00, 1'b1, 5'h01, 5'h01})
      $display("FAIL reset_consts: burst=%02b/%02b len=%0d/%0d wlast=%0b id=%0h/%0h required 01/01 0/0 1 1/1",
               m_awburst_o, m_arburst_o, m_awlen_o, m_arlen_o, m_wlast_o, m_awid_o, m_arid_o);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_write();
    int lat, b0;
    b0 = b_hs;
    sb.push_back(rsp_t'{wr: 1'b1, rdata: 8'h00, resp: 2'b00, err: 1'b0});
    issue_cmd(1'b1, 32'h2000_0000, 8'hA5);
    wait_rsp(lat);
    n_chk++;
    if (lat !== 3) $display("FAIL write_latency: got %0d cycles required 3", lat);
    else n_pass++;
    n_chk++;
    if (aw_seen !== 32'h2000_0000 || w_seen !== 8'hA5)
      $display("FAIL write_beat: got addr=%08h data=%02h required 20000000/a5", aw_seen, w_seen);
    else n_pass++;
    n_chk++;
    if (b_hs - b0 !== 1) $display("FAIL write_b_count: got %0d required 1", b_hs - b0);
    else n_pass++;
    ack_rsp("basic_write");
  endtask

  task automatic test_basic_read();
    int lat;
    sb.push_back(rsp_t'{wr: 1'b0, rdata: 8'hA5, resp: 2'b00, err: 1'b0});
    issue_cmd(1'b0, 32'h2000_0000, 8'h00);
    wait_rsp(lat);
    n_chk++;
    if (lat !== 3) $display("FAIL read_latency: got %0d cycles required 3", lat);
    else n_pass++;
    n_chk++;
    if (ar_seen !== 32'h2000_0000) $display("FAIL read_addr: got %08h required 20000000", ar_seen);
    else n_pass++;
    ack_rsp("basic_read");
  endtask

  task automatic test_split_write();
    int lat, a0, w0, b0;
    aw_delay = 3;
    a0 = aw_cyc; w0 = w_cyc; b0 = b_hs;
    sb.push_back(rsp_t'{wr: 1'b1, rdata: 8'h00, resp: 2'b00, err: 1'b0});
    issue_cmd(1'b1, 32'h2000_0001, 8'h5A);
    wait_rsp(lat);
    n_chk++;
    if (aw_cyc - a0 !== 4 || w_cyc - w0 !== 1)
      $display("FAIL split_valid_cycles: got aw=%0d w=%0d required aw=4 w=1", aw_cyc - a0, w_cyc - w0);
    else n_pass++;
    n_chk++;
    if (b_hs - b0 !== 1 || aw_seen !== 32'h2000_0001 || w_seen !== 8'h5A)
      $display("FAIL split_beat: got b=%0d addr=%08h data=%02h required 1/20000001/5a",
               b_hs - b0, aw_seen, w_seen);
    else n_pass++;
    ack_rsp("split_write");
    aw_delay = 0;
  endtask

  task automatic test_errors();
    s_rid = 5'h02;
    sb.push_back(rsp_t'{wr: 1'b0, rdata: 8'hA5, resp: 2'b00, err: 1'b1});
    run_txn(1'b0, 32'h2000_0000, 8'h00, "err_rid");
    s_rid = 5'h01; s_rlast = 1'b0;
    sb.push_back(rsp_t'{wr: 1'b0, rdata: 8'hA5, resp: 2'b00, err: 1'b1});
    run_txn(1'b0, 32'h2000_0000, 8'h00, "err_rlast");
    s_rlast = 1'b1; s_bresp = 2'b10;
    sb.push_back(rsp_t'{wr: 1'b1, rdata: 8'h00, resp: 2'b10, err: 1'b0});
    run_txn(1'b1, 32'h2000_0002, 8'h3C, "slverr_write");
    s_bresp = 2'b00; s_rresp = 2'b11;
    sb.push_back(rsp_t'{wr: 1'b0, rdata: 8'h3C, resp: 2'b11, err: 1'b0});
    run_txn(1'b0, 32'h2000_0002, 8'h00, "decerr_read");
    s_rresp = 2'b00; s_bid = 5'h1F;
    sb.push_back(rsp_t'{wr: 1'b1, rdata: 8'h00, resp: 2'b00, err: 1'b1});
    run_txn(1'b1, 32'h2000_0003, 8'h77, "err_bid");
    s_bid = 5'h01;
  endtask

  task automatic test_backpressure();
    int lat, ack_cyc;
    sb.push_back(rsp_t'{wr: 1'b0, rdata: 8'h5A, resp: 2'b00, err: 1'b0});
    issue_cmd(1'b0, 32'h2000_0001, 8'h00);
    wait_rsp(lat);
    // Next command is already pending while the response is held off.
    cmd_wr_i = 1'b1; cmd_addr_i = 32'h2000_0004; cmd_wdata_i = 8'hC3; cmd_vld_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if ({rsp_vld_o, cmd_rdy_o, rsp_wr_o, rsp_rdata_o, rsp_resp_o, rsp_err_o}
          !== {1'b1, 1'b0, 1'b0, 8'h5A, 2'b00, 1'b0})
        $display("FAIL hold_%0d: got vld=%0b cmd_rdy=%0b wr=%0b rdata=%02h resp=%02b err=%0b required 1/0/0/5a/00/0",
                 k, rsp_vld_o, cmd_rdy_o, rsp_wr_o, rsp_rdata_o, rsp_resp_o, rsp_err_o);
      else n_pass++;
      @(negedge clk);
    end
    ack_rsp("backpressure_read");
    ack_cyc = cyc;
    sb.push_back(rsp_t'{wr: 1'b1, rdata: 8'h00, resp: 2'b00, err: 1'b0});
    issue_cmd(1'b1, 32'h2000_0004, 8'hC3);
    n_chk++;
    if (hs_cyc - ack_cyc !== 1)
      $display("FAIL post_ack_accept: got %0d cycles after ack required 1", hs_cyc - ack_cyc);
    else n_pass++;
    wait_rsp(lat);
    ack_rsp("backpressure_write");
  endtask

  task automatic test_reset_mid();
    int n = 0, b0;
    b_hold = 1'b1;
    issue_cmd(1'b1, 32'h2000_0008, 8'h99);
    while (!m_bready_o && n < 20) begin @(negedge clk); n++; end
    n_chk++;
    if (!m_bready_o) $display("FAIL reach_wr_resp: m_bready_o=0 required 1");
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({cmd_rdy_o, m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o, rsp_vld_o}
        !== 7'b1000000)
      $display("FAIL mid_reset: got %07b required 1000000", {cmd_rdy_o, m_awvalid_o,
               m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o, rsp_vld_o});
    else n_pass++;
    #1;
    rst_n = 1'b1; b_hold = 1'b0;
    b0 = b_hs;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_vld_o !== 1'b0 || b_hs !== b0)
        $display("FAIL no_rsp_after_reset_%0d: got vld=%0b b=%0d required 0/0", k, rsp_vld_o, b_hs - b0);
      else n_pass++;
    end
    sb.push_back(rsp_t'{wr: 1'b0, rdata: 8'hA5, resp: 2'b00, err: 1'b0});
    run_txn(1'b0, 32'h2000_0000, 8'h00, "read_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] data [4];
    int prev;
    for (int i = 0; i < 4; i++) data[i] = 8'($urandom_range(0, 255));
    for (int j = 0; j < 8; j++) begin
      int i = j % 4;
      if (j < 4) begin
        sb.push_back(rsp_t'{wr: 1'b1, rdata: 8'h00, resp: 2'b00, err: 1'b0});
        run_txn(1'b1, 32'h2000_0010 + 32'(i), data[i], "b2b_write");
      end else begin
        sb.push_back(rsp_t'{wr: 1'b0, rdata: data[i], resp: 2'b00, err: 1'b0});
        run_txn(1'b0, 32'h2000_0010 + 32'(i), 8'h00, "b2b_read");
      end
      if (j > 0) begin
        n_chk++;
        if (hs_cyc - prev !== 4)
          $display("FAIL b2b_spacing_%0d: got %0d cycles required 4", j, hs_cyc - prev);
        else n_pass++;
      end
      prev = hs_cyc;
    end
  endtask

  initial begin
    aw_delay = 0; w_delay = 0; b_hold = 1'b0;
    s_bid = 5'h01; s_rid = 5'h01; s_bresp = 2'b00; s_rresp = 2'b00; s_rlast = 1'b1;
    test_reset();
    test_basic_write();
    test_basic_read();
    test_split_write();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    n_chk++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
